// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: observes the CPU run/stall/flush activity with live
// counters. On request it streams a 177-byte snapshot frame over an 8-bit
// valid/ready byte interface. The frame holds 0xA5, the counters, the PC,
// all registers and the data-memory bytes.
// Ports: clk_i/rst_i (sync active-high), start_i/stall_i/flush_i/pc_i (CPU
// status), dump_i (frame request), reg_addr_o/reg_data_i and
// mem_addr_o/mem_data_i (live read ports), tx_data_o/tx_valid_o/tx_ready_i
// (byte stream), busy_o, cycle_o/stall_cnt_o/flush_cnt_o (live counters).
module cpu_state_dumper #(
    parameter int NUM_REGS  = 32,
    parameter int MEM_BYTES = 32,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic             dump_i,
    output logic [4:0]       reg_addr_o,
    input  logic [31:0]      reg_data_i,
    output logic [4:0]       mem_addr_o,
    input  logic [7:0]       mem_data_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CNT,
        S_REG_LD,
        S_REG_TX,
        S_MEM_LD,
        S_MEM_TX
    } state_t;

    localparam logic [4:0] REG_LAST = 5'(NUM_REGS - 1);
    localparam logic [4:0] MEM_LAST = 5'(MEM_BYTES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [4:0]       reg_addr_q, reg_addr_d;
    logic [4:0]       mem_addr_q, mem_addr_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      snap_cyc_q, snap_cyc_d;
    logic [31:0]      snap_stl_q, snap_stl_d;
    logic [31:0]      snap_fl_q, snap_fl_d;
    logic [31:0]      snap_pc_q, snap_pc_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic [31:0] cyc_ext, stl_ext, fl_ext;
    logic [31:0] snap_w;
    logic        accept;

    // Counters are zero-extended into the 32-bit frame fields.
    always_comb begin
        cyc_ext = '0;
        stl_ext = '0;
        fl_ext  = '0;
        cyc_ext[CNT_W-1:0] = cycle_q;
        stl_ext[CNT_W-1:0] = stall_q;
        fl_ext[CNT_W-1:0]  = flush_q;
    end

    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (start_i) begin
            cycle_d = cycle_q + 1'b1;
            if (stall_i) stall_d = stall_q + 1'b1;
            if (flush_i) flush_d = flush_q + 1'b1;
        end
    end

    // Snapshot word select for the counter/PC section.
    always_comb begin
        unique case (idx_q[3:2])
            2'd0:    snap_w = snap_cyc_q;
            2'd1:    snap_w = snap_stl_q;
            2'd2:    snap_w = snap_fl_q;
            default: snap_w = snap_pc_q;
        endcase
    end

    // Outputs decode from registered state only, so they stay stable
    // for as long as the sink holds off ready.
    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        unique case (state_q)
            S_HDR: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'hA5;
            end
            S_CNT: begin
                tx_valid_o = 1'b1;
                tx_data_o  = snap_w[8*idx_q[1:0] +: 8];
            end
            S_REG_TX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = buf_q[8*idx_q[1:0] +: 8];
            end
            S_MEM_TX: begin
                tx_valid_o = 1'b1;
                tx_data_o  = buf_q[7:0];
            end
            default: begin
                tx_valid_o = 1'b0;
                tx_data_o  = 8'h00;
            end
        endcase
    end

    assign accept = tx_valid_o & tx_ready_i;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        buf_d      = buf_q;
        snap_cyc_d = snap_cyc_q;
        snap_stl_d = snap_stl_q;
        snap_fl_d  = snap_fl_q;
        snap_pc_d  = snap_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (dump_i) begin
                    // Pre-increment counter values of this edge.
                    state_d    = S_HDR;
                    snap_cyc_d = cyc_ext;
                    snap_stl_d = stl_ext;
                    snap_fl_d  = fl_ext;
                    snap_pc_d  = pc_i;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d = S_CNT;
                    idx_d   = 4'd0;
                end
            end
            S_CNT: begin
                if (accept) begin
                    if (idx_q == 4'd15) begin
                        state_d    = S_REG_LD;
                        reg_addr_d = 5'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_REG_LD: begin
                buf_d   = reg_data_i;
                idx_d   = 4'd0;
                state_d = S_REG_TX;
            end
            S_REG_TX: begin
                if (accept) begin
                    if (idx_q[1:0] == 2'd3) begin
                        if (reg_addr_q < REG_LAST) begin
                            reg_addr_d = reg_addr_q + 5'd1;
                            state_d    = S_REG_LD;
                        end else begin
                            mem_addr_d = 5'd0;
                            state_d    = S_MEM_LD;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_MEM_LD: begin
                buf_d   = {24'h0, mem_data_i};
                state_d = S_MEM_TX;
            end
            S_MEM_TX: begin
                if (accept) begin
                    if (mem_addr_q < MEM_LAST) begin
                        mem_addr_d = mem_addr_q + 5'd1;
                        state_d    = S_MEM_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            buf_q      <= '0;
            snap_cyc_q <= '0;
            snap_stl_q <= '0;
            snap_fl_q  <= '0;
            snap_pc_q  <= '0;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
            buf_q      <= buf_d;
            snap_cyc_q <= snap_cyc_d;
            snap_stl_q <= snap_stl_d;
            snap_fl_q  <= snap_fl_d;
            snap_pc_q  <= snap_pc_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign reg_addr_o  = reg_addr_q;
    assign mem_addr_o  = mem_addr_q;
    assign cycle_o     = cycle_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb_cpu_state_dumper: directed bench for cpu_state_dumper, with a 32-bit
// counter instance and a 4-bit counter instance for the wrap case.
module tb_cpu_state_dumper;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] pc_i = 32'h0;
    logic        dump_i = 1'b0;
    logic        tx_ready_i = 1'b1;
    logic [4:0]  reg_addr_o, mem_addr_o;
    logic [31:0] reg_data_i;
    logic [7:0]  mem_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, busy_o;
    logic [31:0] cycle_o, stall_cnt_o, flush_cnt_o;

    logic        start4 = 1'b0;
    logic        dump4 = 1'b0;
    logic [4:0]  reg_addr4, mem_addr4;
    logic [31:0] reg_data4;
    logic [7:0]  mem_data4;
    logic [7:0]  data4;
    logic        valid4, busy4;
    logic [3:0]  cyc4, stl4, fl4;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_cyc = 0, m_stl = 0, m_fl = 0;

    always #5 clk = ~clk;

    assign reg_data_i = 32'(reg_addr_o) * 32'h01010101;
    assign mem_data_i = {3'b000, mem_addr_o};
    assign reg_data4  = 32'(reg_addr4) * 32'h01010101;
    assign mem_data4  = {3'b000, mem_addr4};

    cpu_state_dumper u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .stall_i(stall_i), .flush_i(flush_i), .pc_i(pc_i),
        .dump_i(dump_i), .reg_addr_o(reg_addr_o),
        .reg_data_i(reg_data_i), .mem_addr_o(mem_addr_o),
        .mem_data_i(mem_data_i), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .busy_o(busy_o), .cycle_o(cycle_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    cpu_state_dumper #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start4),
        .stall_i(stall_i), .flush_i(flush_i), .pc_i(pc_i),
        .dump_i(dump4), .reg_addr_o(reg_addr4),
        .reg_data_i(reg_data4), .mem_addr_o(mem_addr4),
        .mem_data_i(mem_data4), .tx_data_o(data4),
        .tx_valid_o(valid4), .tx_ready_i(1'b1),
        .busy_o(busy4), .cycle_o(cyc4),
        .stall_cnt_o(stl4), .flush_cnt_o(fl4)
    );

    // Reference counters for the 32-bit instance.
    always @(posedge clk) begin
        if (rst_i) begin
            m_cyc = 0;
            m_stl = 0;
            m_fl  = 0;
        end else if (start_i) begin
            m_cyc = m_cyc + 1;
            if (stall_i) m_stl = m_stl + 1;
            if (flush_i) m_fl = m_fl + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int k,
        input logic [31:0] c, input logic [31:0] s,
        input logic [31:0] f, input logic [31:0] p);
        logic [31:0] w;
        if (k == 0) return 8'hA5;
        if (k < 17) begin
            case ((k - 1) / 4)
                0:       w = c;
                1:       w = s;
                2:       w = f;
                default: w = p;
            endcase
            return w[8*((k-1)%4) +: 8];
        end
        if (k < 145) begin
            w = 32'((k - 17) / 4) * 32'h01010101;
            return w[8*((k-17)%4) +: 8];
        end
        return 8'(k - 145);
    endfunction

    task automatic watch_quiet(input string tag);
        logic seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | tx_valid_o | busy_o;
        end
        chk(tag, 32'(seen), 0);
    endtask

    // Called at a negedge. bp: random ready; pulse: spurious dump_i
    // during the frame; rst_at: byte count at which reset is applied.
    task automatic run_frame(input bit bp, input bit pulse,
                             input int rst_at);
        logic [31:0] sc, ss, sf, sp;
        logic [7:0]  held = 8'h00;
        bit          stalled = 1'b0;
        int          nb = 0, nbusy = 0, cyc = 0;
        sc = m_cyc;
        ss = m_stl;
        sf = m_fl;
        sp = pc_i;
        dump_i = 1'b1;
        @(negedge clk);
        chk("latency_valid", 32'(tx_valid_o), 1);
        dump_i = 1'b0;
        while (busy_o && cyc < 4000) begin
            nbusy++;
            if (stalled) begin
                chk("hold_valid", 32'(tx_valid_o), 1);
                chk("hold_data", 32'(tx_data_o), 32'(held));
            end
            if (pulse) dump_i = (cyc % 3 == 0) && (nb < 170);
            tx_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_at >= 0 && nb == rst_at) begin
                rst_i = 1'b1;
                break;
            end
            if (tx_valid_o && tx_ready_i) begin
                chk($sformatf("byte%0d", nb), 32'(tx_data_o),
                    32'(exp_byte(nb, sc, ss, sf, sp)));
                nb++;
                stalled = 1'b0;
            end else begin
                stalled = tx_valid_o;
                held = tx_data_o;
            end
            cyc++;
            @(negedge clk);
        end
        dump_i = 1'b0;
        tx_ready_i = 1'b1;
        if (cyc >= 4000) chk("frame_timeout", 1, 0);
        if (rst_at >= 0) begin
            @(negedge clk);
            rst_i = 1'b0;
            chk("rst_valid", 32'(tx_valid_o), 0);
            chk("rst_busy", 32'(busy_o), 0);
            chk("rst_cycle", cycle_o, 0);
            chk("rst_stall", stall_cnt_o, 0);
            chk("rst_bytes_before", nb, rst_at);
        end else begin
            chk("frame_bytes", nb, 177);
            if (!bp) chk("busy_len", nbusy, 241);
        end
    endtask

    initial begin
        logic [7:0] hdr4 [5];
        int         w;
        hdr4 = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00};

        // Reset
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(tx_valid_o), 0);
        chk("reset_data", 32'(tx_data_o), 0);
        chk("reset_busy", 32'(busy_o), 0);
        chk("reset_raddr", 32'(reg_addr_o), 0);
        chk("reset_maddr", 32'(mem_addr_o), 0);
        chk("reset_cycle", cycle_o, 0);
        chk("reset_stall", stall_cnt_o, 0);
        chk("reset_flush", flush_cnt_o, 0);
        rst_i = 1'b0;
        stall_i = 1'b1;
        flush_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cycle", cycle_o, 0);
        chk("idle_stall", stall_cnt_o, 0);
        chk("idle_flush", flush_cnt_o, 0);

        // Counters: stalls on 3 cycles, flushes on 2 (one overlapping)
        for (int i = 0; i < 20; i++) begin
            start_i = 1'b1;
            stall_i = (i == 2) || (i == 6) || (i == 11);
            flush_i = (i == 6) || (i == 14);
            @(negedge clk);
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        chk("cnt_cycle", cycle_o, 20);
        chk("cnt_stall", stall_cnt_o, 3);
        chk("cnt_flush", flush_cnt_o, 2);

        // Full frame, ready tied high
        pc_i = 32'h40;
        run_frame(1'b0, 1'b0, -1);
        watch_quiet("quiet_after_a");

        // Backpressure, counters running, spurious requests
        pc_i = 32'hDEAD_BEEF;
        start_i = 1'b1;
        stall_i = 1'b1;
        run_frame(1'b1, 1'b1, -1);
        start_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        chk("run_cycle", cycle_o, m_cyc);
        chk("run_stall", stall_cnt_o, m_stl);
        chk("run_flush", flush_cnt_o, m_fl);
        watch_quiet("quiet_after_b");

        // Reset mid-frame at byte 60
        pc_i = 32'h1234_5678;
        run_frame(1'b0, 1'b1, 60);
        watch_quiet("quiet_after_rst");

        // 4-bit counters wrap: 18 cycles -> 2
        for (int i = 0; i < 18; i++) begin
            start4 = 1'b1;
            @(negedge clk);
        end
        start4 = 1'b0;
        chk("w4_cycle", 32'(cyc4), 2);
        chk("w4_stall", 32'(stl4), 0);
        chk("w4_flush", 32'(fl4), 0);
        dump4 = 1'b1;
        @(negedge clk);
        dump4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("w4_byte%0d", k), 32'(data4), 32'(hdr4[k]));
            @(negedge clk);
        end
        w = 0;
        while (busy4 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("w4_done", 32'(busy4), 0);
        chk("w4_valid", 32'(valid4), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
